// File: rtl/arb2_mem_ctrl_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// - state_e        : sequencer states; encoding 2'd3 is unused and falls back to idle
// - DefaultTimeout : default BUSY-cycle budget before a transaction is failed
// - pick_winner    : round-robin choice between the two requesters
package arb2_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam int unsigned DefaultTimeout = 16;

    // On a tie the requester that was not served last wins; otherwise whoever asks.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            return !last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/arb2_mem_ctrl_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// - slave  : arbiter view (requests and memory responses in, grants/commands out)
// - master : environment view (requesters plus memory model)
interface arb2_mem_ctrl_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          we0;
    logic          we1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          done0;
    logic          done1;
    logic          err;
    logic [DW-1:0] rdata;
    logic          sel;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ready,
        output done0, done1, err, rdata, sel, mem_valid, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata, mem_ready,
        input  done0, done1, err, rdata, sel, mem_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/arb2_mem_ctrl_mux2x1.sv
// One-bit 2:1 multiplexer.
// - a_i : selected when s_i = 0
// - b_i : selected when s_i = 1
// - s_i : select
// - y_o : output
module arb2_mem_ctrl_mux2x1 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);
    assign y_o = s_i ? b_i : a_i;
endmodule

// File: rtl/arb2_mem_ctrl.sv
// Round-robin arbiter and sequencer for one shared memory port.
// - clk : rising-edge clock
// - rst : asynchronous active-high reset
// - bus : requester and memory signals (slave modport)
// Grants one requester, holds sel for a whole transaction, drives the memory
// command during BUSY and returns rdata or a timeout error with a done pulse.
module arb2_mem_ctrl
    import arb2_mem_ctrl_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic             clk,
    input  logic             rst,
    arb2_mem_ctrl_if.slave   bus
);
    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned MuxW = AW + DW + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [MuxW-1:0] mux_a, mux_b, mux_y;
    logic            mux_we;
    logic            busy;

    // Address, write enable and write data share one bit-sliced mux.
    assign mux_a = {bus.addr0, bus.we0, bus.wdata0};
    assign mux_b = {bus.addr1, bus.we1, bus.wdata1};

    for (genvar i = 0; i < MuxW; i++) begin : g_mux
        arb2_mem_ctrl_mux2x1 u_mux (
            .a_i (mux_a[i]),
            .b_i (mux_b[i]),
            .s_i (sel_q),
            .y_o (mux_y[i])
        );
    end

    assign mux_we = mux_y[DW];
    assign busy   = (state_q == StBusy);

    assign bus.mem_addr  = mux_y[MuxW-1 -: AW];
    assign bus.mem_wdata = mux_y[DW-1:0];
    assign bus.mem_we    = mux_we & busy;
    assign bus.mem_valid = busy;
    assign bus.sel       = sel_q;
    assign bus.rdata     = rdata_q;
    assign bus.err       = err_q;
    assign bus.done0     = (state_q == StResp) & ~sel_q;
    assign bus.done1     = (state_q == StResp) & sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    sel_d   = pick_winner(bus.req0, bus.req1, last_q);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A ready on the final budget cycle still completes without error.
                if (bus.mem_ready) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    last_d  = sel_q;
                    state_d = StResp;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    last_d  = sel_q;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_arb2_mem_ctrl.sv
// Directed self-checking bench for arb2_mem_ctrl (TIMEOUT = 4).
module tb_arb2_mem_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    arb2_mem_ctrl_if #(.AW(32), .DW(32)) bus ();

    arb2_mem_ctrl #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.mem_valid); end
        n_cmp++; if (bus.sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", bus.sel); end
        n_cmp++; if ({bus.done0, bus.done1} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b exp 00", {bus.done0, bus.done1}); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.err); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
    endtask

    task automatic test_basic_read();
        bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.we0 = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE;
        #1;
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b exp 0", bus.mem_valid); end
        step();
        n_cmp++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL basic_busy_valid got %b exp 1", bus.mem_valid); end
        n_cmp++; if (bus.sel !== 1'b0) begin n_fail++; $display("FAIL basic_sel got %b exp 0", bus.sel); end
        n_cmp++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL basic_addr got %h exp 10", bus.mem_addr); end
        n_cmp++; if (bus.done0 !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got %b exp 0", bus.done0); end
        step();
        n_cmp++; if ({bus.done0, bus.done1} !== 2'b10) begin n_fail++; $display("FAIL basic_done got %b exp 10", {bus.done0, bus.done1}); end
        n_cmp++; if (bus.rdata !== 32'hCAFE) begin n_fail++; $display("FAIL basic_rdata got %h exp cafe", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", bus.err); end
        n_cmp++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL basic_resp_valid got %b exp 0", bus.mem_valid); end
        bus.req0 = 1'b0;
        step();
        n_cmp++; if (bus.done0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_len got %b exp 0", bus.done0); end
    endtask

    task automatic test_round_robin();
        logic exp_sel;
        int   dones;
        do_reset();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.addr0 = 32'h100; bus.addr1 = 32'h200;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            exp_sel = k[0];
            step();
            n_cmp++; if (bus.sel !== exp_sel) begin n_fail++; $display("FAIL rr_sel[%0d] got %b exp %b", k, bus.sel, exp_sel); end
            n_cmp++; if (bus.mem_addr !== (exp_sel ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL rr_addr[%0d] got %h exp %h", k, bus.mem_addr, exp_sel ? 32'h200 : 32'h100); end
            dones += int'(bus.done0) + int'(bus.done1);
            step();
            n_cmp++; if ({bus.done0, bus.done1} !== (exp_sel ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_done[%0d] got %b exp %b", k, {bus.done0, bus.done1}, exp_sel ? 2'b01 : 2'b10); end
            dones += int'(bus.done0) + int'(bus.done1);
            step();
            dones += int'(bus.done0) + int'(bus.done1);
        end
        n_cmp++; if (dones !== 4) begin n_fail++; $display("FAIL rr_done_count got %0d exp 4", dones); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_write();
        bus.req1 = 1'b1; bus.addr1 = 32'h20; bus.we1 = 1'b1; bus.wdata1 = 32'h55;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_idle_we got %b exp 0", bus.mem_we); end
        step();
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL wr_busy_we got %b exp 1", bus.mem_we); end
        n_cmp++; if (bus.mem_wdata !== 32'h55) begin n_fail++; $display("FAIL wr_wdata got %h exp 55", bus.mem_wdata); end
        n_cmp++; if (bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL wr_addr got %h exp 20", bus.mem_addr); end
        step();
        n_cmp++; if ({bus.done0, bus.done1} !== 2'b01) begin n_fail++; $display("FAIL wr_done got %b exp 01", {bus.done0, bus.done1}); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_resp_we got %b exp 0", bus.mem_we); end
        n_cmp++; if (bus.rdata !== 32'h1234) begin n_fail++; $display("FAIL wr_rdata got %h exp 1234", bus.rdata); end
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.req0 = 1'b1; bus.addr0 = 32'h44; bus.we0 = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hFFFF;
        step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({bus.mem_valid, bus.done0} !== 2'b10) begin n_fail++; $display("FAIL to_busy[%0d] got %b exp 10", i, {bus.mem_valid, bus.done0}); end
            step();
        end
        n_cmp++; if ({bus.done0, bus.err, bus.mem_valid} !== 3'b110) begin n_fail++; $display("FAIL to_done_err got %b exp 110", {bus.done0, bus.err, bus.mem_valid}); end
        n_cmp++; if (bus.rdata !== 32'h1234) begin n_fail++; $display("FAIL to_rdata_kept got %h exp 1234", bus.rdata); end
        bus.req0 = 1'b0;
        step();
        n_cmp++; if ({bus.done0, bus.mem_valid} !== 2'b00) begin n_fail++; $display("FAIL to_idle got %b exp 00", {bus.done0, bus.mem_valid}); end
        bus.req0 = 1'b1; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBEEF;
        step();
        step();
        n_cmp++; if ({bus.done0, bus.err} !== 2'b10) begin n_fail++; $display("FAIL to_next_done got %b exp 10", {bus.done0, bus.err}); end
        n_cmp++; if (bus.rdata !== 32'hBEEF) begin n_fail++; $display("FAIL to_next_rdata got %h exp beef", bus.rdata); end
        bus.req0 = 1'b0;
        step();
    endtask

    task automatic test_ready_at_timeout();
        bus.req0 = 1'b1; bus.mem_ready = 1'b0; bus.mem_rdata = 32'hD00D;
        step();
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (bus.mem_valid !== 1'b1) begin n_fail++; $display("FAIL rt_last_busy got %b exp 1", bus.mem_valid); end
        bus.mem_ready = 1'b1;
        step();
        n_cmp++; if ({bus.done0, bus.err} !== 2'b10) begin n_fail++; $display("FAIL rt_done_err got %b exp 10", {bus.done0, bus.err}); end
        n_cmp++; if (bus.rdata !== 32'hD00D) begin n_fail++; $display("FAIL rt_rdata got %h exp d00d", bus.rdata); end
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.mem_ready = 1'b0;
        step();
        n_cmp++; if ({bus.sel, bus.mem_valid} !== 2'b11) begin n_fail++; $display("FAIL rm_pre_busy got %b exp 11", {bus.sel, bus.mem_valid}); end
        step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.mem_valid, bus.sel, bus.done0, bus.done1} !== 4'b0000) begin n_fail++; $display("FAIL rm_async got %b exp 0000", {bus.mem_valid, bus.sel, bus.done0, bus.done1}); end
        step();
        rst = 1'b0;
        step();
        n_cmp++; if ({bus.sel, bus.mem_valid} !== 2'b01) begin n_fail++; $display("FAIL rm_tie_after got %b exp 01", {bus.sel, bus.mem_valid}); end
        bus.mem_ready = 1'b1;
        step();
        n_cmp++; if ({bus.done0, bus.done1} !== 2'b10) begin n_fail++; $display("FAIL rm_done got %b exp 10", {bus.done0, bus.done1}); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_write();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb2_mem_ctrl.md
# arb2_mem_ctrl

Two-requester arbiter and sequencer for one shared memory port. It owns the select line of the 2:1 address/data multiplexer in front of the memory, for example instruction fetch versus load/store on a single-port RAM. It grants the port round-robin, holds the grant for one complete memory transaction, and returns read data or a timeout error to the winning requester.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum cycles in BUSY waiting for mem_ready (≥2)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- req0, req1  in  1  transaction request from requester 0 / 1
- addr0, addr1  in  AW  request address
- we0, we1  in  1  1 = write, 0 = read
- wdata0, wdata1  in  DW  write data
- done0, done1  out  1  one-cycle completion pulse to the requester
- err  out  1  qualifies the done pulse: transaction timed out
- rdata  out  DW  registered read data, valid while done is high
- sel  out  1  multiplexer select (0 = requester 0), registered
- mem_valid  out  1  memory command strobe
- mem_addr  out  AW  selected address
- mem_we  out  1  selected write enable
- mem_wdata  out  DW  selected write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completes the command this cycle

Decided: one clock; reset is asynchronous and active-high.

## Operation
- The FSM has three states: IDLE, BUSY and RESP. Reset puts it in IDLE with sel=0, last=1, cnt=0, rdata=0, err=0, done0=done1=0 and mem_valid=0.
- IDLE, no requests: hold. If exactly one request is high, that requester wins. If both are high, the requester not equal to `last` wins (round-robin). On the edge, sel<=winner and the FSM goes to BUSY.
- BUSY:
  - mem_valid=1.
  - mem_addr, mem_we and mem_wdata are the sel-multiplexed requester inputs.
  - On mem_ready: rdata<=mem_rdata (also for writes), err<=0, last<=sel, and the FSM goes to RESP.
  - Otherwise cnt increments. When cnt==TIMEOUT-1 and mem_ready=0: err<=1, last<=sel, the FSM goes to RESP, and rdata is unchanged.
- RESP: done[sel]=1 for exactly one cycle, err remains valid, cnt<=0, and the FSM goes to IDLE.
- In IDLE and RESP, mem_valid=0. In those states mem_addr, mem_we and mem_wdata still show the sel input, and mem_we is forced to 0.
- Requester contract:
  - Hold req, addr, we and wdata stable from assertion until its done.
  - A requester dropping req while in BUSY is ignored; the transaction completes.
  - A req still high in IDLE after done counts as a new request.
- A requester that is not granted sees no done and waits. Round-robin guarantees service within one transaction.

## Timing
- Request sampled at edge E0 → BUSY from E0+1 (mem_valid high).
- mem_ready in the first BUSY cycle → RESP next cycle → done. The minimum is 3 cycles from req to the done cycle, and 3 cycles per transaction back-to-back.
- Timeout: mem_valid is high for exactly TIMEOUT cycles, then done+err.
- Simultaneous req0 and req1 with continuous traffic: grants alternate 0,1,0,1 and the first tie after reset goes to requester 0.
- mem_ready while in IDLE or RESP is ignored.
- mem_ready on the same cycle as cnt==TIMEOUT-1: ready wins and err=0.
- rst asserted mid-transaction: all outputs go to their reset values immediately (asynchronous). mem_valid drops without waiting for an edge, no done is produced, and the in-flight transaction is lost.

## Structure
- Shared header arb2_defs.vh holds the state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and the default TIMEOUT. Encoding 2'd3 returns to IDLE.
- The sub-module is the existing 1-bit mux2x1, instantiated in a generate loop over AW+DW+1 bits with its s input driven by sel. The FSM, counter and round-robin pointer live in the top module.

## Test plan
- Reset, then req0=1, addr0=0x10, we0=0, with memory answering mem_ready in the first BUSY cycle and mem_rdata=0xCAFE → sel=0, mem_addr=0x10, done0 on the 3rd cycle, rdata=0xCAFE, err=0.
- req0 and req1 held high for 4 transactions → grant order 0,1,0,1. done pulses never overlap, and exactly one done per transaction.
- req1 write with addr1=0x20 and wdata1=0x55 while req0 is idle → mem_we=1 and mem_wdata=0x55 only during BUSY, followed by done1.
- With TIMEOUT=4, mem_ready is never asserted → 4 cycles of mem_valid, then done0=1 with err=1, then IDLE; the next request proceeds normally.
- rst asserted during BUSY → mem_valid=0, sel=0 and done=0 immediately. After release, a tie goes to requester 0.
- mem_ready asserted on the exact timeout cycle → err=0 and rdata is captured.
